quick_spi_hard_ctrl: RTL and testbench
======================================

// Module: quick_spi_hard_ctrl
// PURPOSE
//  Parameterised SPI master: shifts a multi-byte word out on mosi and, for reads, then captures a word from miso.
//  Sits between a local register/command interface and up to 4 external SPI slaves.
//  Configurable byte/bit ordering, clock mode and trailing idle toggles. One-cycle end_of_transaction pulse.
// PARAMETERS
//  OUTGOING_DATA_WIDTH      16  bits sent per transaction (multiple of 8)
//  INCOMING_DATA_WIDTH      8   bits captured on read (multiple of 8)
//  CPOL                     0   sclk idle level
//  CPHA                     0   0: sample leading edge, shift trailing; 1: shift leading, sample trailing
//  BYTES_ORDER              0   0: little endian (byte [7:0] first); 1: big endian (top byte first)
//  BITS_ORDER               0   0: LSB first within byte; 1: MSB first
//  NUMBER_OF_SLAVES         2   ss_n width, 1..4
//  EXTRA_WRITE_SCLK_TOGGLES 6   extra sclk toggles appended after a write
//  EXTRA_READ_SCLK_TOGGLES  4   sclk toggles between outgoing and incoming phases of a read
// PORTS
//  clk                 in   1    system clock; one clock; reset is synchronous and active-high
//  reset               in   1    synchronous, active-high reset
//  enable              in   1    block enable; low forces/holds IDLE
//  start_transaction   in   1    level request, sampled in IDLE
//  slave               in   2    binary index of target slave
//  operation           in   1    0 write, 1 read
//  outgoing_data       in   OUTGOING_DATA_WIDTH  data to send
//  incoming_data       out  INCOMING_DATA_WIDTH  last read result
//  end_of_transaction  out  1    one-clk pulse at completion
//  mosi out 1 | miso in 1 | sclk out 1 | ss_n out NUMBER_OF_SLAVES (active-low selects)
// BEHAVIOUR
//  Reset: ss_n all 1, sclk=CPOL, mosi=0, incoming_data=0, end_of_transaction=0, state IDLE.
//  States: IDLE -> WRITE -> (READ if operation=1) -> DONE -> IDLE.
//  IDLE: if enable&start_transaction, latch outgoing_data/operation/slave; next cycle ss_n[slave]=0, enter WRITE.
//  slave >= NUMBER_OF_SLAVES: all ss_n stay 1, transaction still clocks and completes.
//  sclk toggles every clk while active (f_sclk=f_clk/2); one bit per two toggles.
//  WRITE: 2*OUTGOING_DATA_WIDTH toggles; bit order per BYTES_ORDER then BITS_ORDER.
//   CPHA=0: first bit on mosi when ss_n falls. CPHA=1: first bit driven on first leading edge.
//  Write ends with EXTRA_WRITE_SCLK_TOGGLES toggles (mosi=0); read inserts EXTRA_READ_SCLK_TOGGLES then
//   READ: 2*INCOMING_DATA_WIDTH toggles, miso sampled per CPHA, bits placed by same ordering rules.
//  sclk always returns to CPOL before DONE (odd toggle counts rounded up by one).
//  DONE: ss_n all 1, end_of_transaction=1 for exactly one clk; incoming_data updated the same cycle (reads only), held otherwise.
//  start_transaction still high in cycle after DONE: new transaction accepted immediately (operation re-sampled).
//  enable low mid-transaction: abort to IDLE next clk, ss_n=1, sclk=CPOL, no end pulse, incoming_data unchanged.
//  reset mid-transaction: same as power-on reset values.
//  outgoing_data/operation/slave changes during a transaction are ignored (latched copy used).
// CONFIGURATION
//  QUICK_SPI_BUSY_EN defined: extra output busy (1 bit), high from accept cycle through DONE inclusive, 0 on reset.
//  Undefined: no busy port; all other behaviour identical.
// STRUCTURE
//  Package quick_spi_pkg: state enum (IDLE/WRITE/READ/DONE), OP_WRITE=0/OP_READ=1, BYTES_LE/BE, BITS_LSB/MSB constants,
//   bit-index mapping function (serial position -> word bit index for given order params).
//  Sub-module quick_spi_sclk_gen: toggle counter, sclk level, leading/trailing edge strobes.
// TESTING
//  LE/LSB write, outgoing=0xCC82 -> mosi 0,1,0,0,0,0,0,1,0,0,1,1,0,0,1,1; ss_n=2'b01 (slave=1) during; one end pulse.
//  BE/MSB write, outgoing=0xCC82 -> mosi 1,1,0,0,1,1,0,0,1,0,0,0,0,0,1,0.
//  LE/LSB read, miso bits 1,0,1,0,1,0,0,1 in read phase -> incoming_data=0x95 at end pulse; unchanged after next write.
//  start held high, operation toggled each end pulse -> back-to-back write/read, ss_n high exactly 1+ clk between.
//  enable dropped at toggle 10 -> ss_n=all 1, sclk=CPOL next clk, no end_of_transaction; reset mid-read -> reset values.
//  CPOL=1,CPHA=1 write 0x0001 LSB-first -> sclk idles 1, first bit 1 driven on first falling edge.

Source files
------------

// File: rtl/quick_spi_pkg.sv
// Shared types and helpers for the quick_spi SPI master.
// bit_index maps a serial bit position onto a word bit index for a given byte/bit ordering.
package quick_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } spi_state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam int unsigned BYTES_LE = 0;
  localparam int unsigned BYTES_BE = 1;
  localparam int unsigned BITS_LSB = 0;
  localparam int unsigned BITS_MSB = 1;

  function automatic int unsigned bit_index(input int unsigned pos,
                                            input int unsigned width,
                                            input int unsigned bytes_order,
                                            input int unsigned bits_order);
    int unsigned byte_sel;
    int unsigned bit_sel;
    byte_sel = pos / 8;
    bit_sel  = pos % 8;
    if (bytes_order == BYTES_BE) byte_sel = width / 8 - 1 - byte_sel;
    if (bits_order == BITS_MSB) bit_sel = 7 - bit_sel;
    return byte_sel * 8 + bit_sel;
  endfunction

endpackage

// File: rtl/quick_spi_sclk_gen.sv
// SPI clock generator: toggles sclk every clk while run is high, counts toggles,
// and flags whether the coming toggle is a leading or trailing edge.
module quick_spi_sclk_gen #(
  parameter int unsigned CPOL  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             sclk,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             lead,
  output logic             trail
);

  localparam logic SCLK_IDLE = 1'(CPOL);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      sclk       <= SCLK_IDLE;
      toggle_cnt <= '0;
    end else begin
      sclk       <= ~sclk;
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end

  // Leaving the idle level is the leading edge.
  assign lead  = run && (sclk == SCLK_IDLE);
  assign trail = run && (sclk != SCLK_IDLE);

endmodule

// File: rtl/quick_spi_hard_ctrl.sv
// Parameterised SPI master: shifts out a multi-byte word, optionally captures a read word.
// Optional QUICK_SPI_BUSY_EN adds a busy output covering accept through DONE.
module quick_spi_hard_ctrl
  import quick_spi_pkg::*;
#(
  parameter int unsigned OUTGOING_DATA_WIDTH      = 16,
  parameter int unsigned INCOMING_DATA_WIDTH      = 8,
  parameter int unsigned CPOL                     = 0,
  parameter int unsigned CPHA                     = 0,
  parameter int unsigned BYTES_ORDER              = 0,
  parameter int unsigned BITS_ORDER               = 0,
  parameter int unsigned NUMBER_OF_SLAVES         = 2,
  parameter int unsigned EXTRA_WRITE_SCLK_TOGGLES = 6,
  parameter int unsigned EXTRA_READ_SCLK_TOGGLES  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           start_transaction,
  input  logic [1:0]                     slave,
  input  logic                           operation,
  input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
  output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
  output logic                           end_of_transaction,
`ifdef QUICK_SPI_BUSY_EN
  output logic                           busy,
`endif
  output logic                           mosi,
  input  logic                           miso,
  output logic                           sclk,
  output logic [NUMBER_OF_SLAVES-1:0]    ss_n
);

  localparam int unsigned OW       = OUTGOING_DATA_WIDTH;
  localparam int unsigned IW       = INCOMING_DATA_WIDTH;
  localparam int unsigned WR_T     = 2 * OW;
  localparam int unsigned RD_T     = 2 * IW;
  localparam int unsigned XW       = EXTRA_WRITE_SCLK_TOGGLES + EXTRA_WRITE_SCLK_TOGGLES % 2;
  localparam int unsigned XR       = EXTRA_READ_SCLK_TOGGLES + EXTRA_READ_SCLK_TOGGLES % 2;
  localparam int unsigned WR_TOTAL = WR_T + XW;
  localparam int unsigned RD_START = WR_T + XR;
  localparam int unsigned RD_TOTAL = RD_START + RD_T;
  localparam int unsigned MAX_T    = (WR_TOTAL > RD_TOTAL) ? WR_TOTAL : RD_TOTAL;
  localparam int unsigned CNT_W    = $clog2(MAX_T + 1);
  localparam int unsigned OW_IDX_W = $clog2(OW);
  localparam int unsigned IW_IDX_W = $clog2(IW);

  localparam logic [CNT_W-1:0] WR_LAST_WR = CNT_W'(WR_TOTAL - 1);
  localparam logic [CNT_W-1:0] WR_LAST_RD = CNT_W'(WR_T - 1);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_TOTAL - 1);
  localparam logic [OW_IDX_W-1:0] FIRST_IDX =
    OW_IDX_W'(bit_index(0, OW, BYTES_ORDER, BITS_ORDER));
  localparam logic CPHA_B = 1'(CPHA);

  spi_state_t            state;
  logic [OW-1:0]         data_q;
  logic                  op_q;
  logic [IW-1:0]         rx_q;
  logic [IW-1:0]         rx_next;
  logic                  run;
  logic                  lead;
  logic                  trail;
  logic [CNT_W-1:0]      toggle_cnt;
  int unsigned           cnt_i;
  int unsigned           tx_pos;
  int unsigned           rx_pos;
  logic [OW_IDX_W-1:0]   tx_idx;
  logic [IW_IDX_W-1:0]   rx_idx;
  logic                  tx_bit;
  logic                  shift_now;
  logic                  sample_now;
  logic [NUMBER_OF_SLAVES-1:0] sel_n;

  assign run = enable && (state == WRITE || state == READ);

  quick_spi_sclk_gen #(
    .CPOL (CPOL),
    .CNT_W(CNT_W)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .sclk      (sclk),
    .toggle_cnt(toggle_cnt),
    .lead      (lead),
    .trail     (trail)
  );

  // Toggle k carries serial bit (k+1)/2 for both phases: CPHA=0 shifts on odd
  // (trailing) toggles, CPHA=1 on even (leading) toggles.
  always_comb begin
    cnt_i      = 32'(toggle_cnt);
    tx_pos     = (cnt_i + 1) >> 1;
    tx_idx     = OW_IDX_W'(bit_index(tx_pos, OW, BYTES_ORDER, BITS_ORDER));
    tx_bit     = (tx_pos < OW) ? data_q[tx_idx] : 1'b0;
    shift_now  = CPHA_B ? lead : trail;
    rx_pos     = (cnt_i - RD_START) >> 1;
    rx_idx     = IW_IDX_W'(bit_index(rx_pos, IW, BYTES_ORDER, BITS_ORDER));
    sample_now = (state == READ) && (cnt_i >= RD_START) && (CPHA_B ? trail : lead);
    rx_next    = rx_q;
    if (sample_now) rx_next[rx_idx] = miso;
    sel_n = '1;
    for (int unsigned i = 0; i < NUMBER_OF_SLAVES; i++) begin
      if (i == 32'(slave)) sel_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      ss_n               <= '1;
      mosi               <= 1'b0;
      incoming_data      <= '0;
      end_of_transaction <= 1'b0;
      data_q             <= '0;
      op_q               <= OP_WRITE;
      rx_q               <= '0;
    end else if (!enable) begin
      state              <= IDLE;
      ss_n               <= '1;
      mosi               <= 1'b0;
      end_of_transaction <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          end_of_transaction <= 1'b0;
          if (start_transaction) begin
            data_q <= outgoing_data;
            op_q   <= operation;
            ss_n   <= sel_n;
            mosi   <= CPHA_B ? 1'b0 : outgoing_data[FIRST_IDX];
            rx_q   <= '0;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (shift_now) mosi <= tx_bit;
          if (op_q == OP_READ) begin
            if (toggle_cnt == WR_LAST_RD) state <= READ;
          end else if (toggle_cnt == WR_LAST_WR) begin
            state              <= DONE;
            ss_n               <= '1;
            end_of_transaction <= 1'b1;
          end
        end
        READ: begin
          if (shift_now) mosi <= tx_bit;
          rx_q <= rx_next;
          // rx_next already holds the bit sampled on the final toggle.
          if (toggle_cnt == RD_LAST) begin
            state              <= DONE;
            ss_n               <= '1;
            end_of_transaction <= 1'b1;
            incoming_data      <= rx_next;
          end
        end
        DONE: begin
          end_of_transaction <= 1'b0;
          mosi               <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QUICK_SPI_BUSY_EN
  assign busy = (state != IDLE);
`else
  // No busy indicator in this build.
`endif

endmodule

// File: tb/tb_quick_spi_hard_ctrl.sv
// Directed bench for quick_spi_hard_ctrl: three instances cover LE/LSB, BE/MSB and
// CPOL=1/CPHA=1; expectations are hand-computed bit sequences and cycle counts.
module tb_quick_spi_hard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [2:0]  start_v = '0;
  logic [1:0]  slave = 2'd1;
  logic        operation = 1'b0;
  logic [15:0] outgoing = '0;
  logic        miso = 1'b0;

  logic [2:0]  sclk_v;
  logic [2:0]  mosi_v;
  logic [2:0]  eot_v;
  logic [1:0]  ss_v [3];
  logic [7:0]  inc_v [3];
`ifdef QUICK_SPI_BUSY_EN
  logic [2:0]  busy_v;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  quick_spi_hard_ctrl #(.BYTES_ORDER(0), .BITS_ORDER(0), .CPOL(0), .CPHA(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .start_transaction(start_v[0]),
    .slave(slave), .operation(operation), .outgoing_data(outgoing),
    .incoming_data(inc_v[0]), .end_of_transaction(eot_v[0]),
`ifdef QUICK_SPI_BUSY_EN
    .busy(busy_v[0]),
`endif
    .mosi(mosi_v[0]), .miso(miso), .sclk(sclk_v[0]), .ss_n(ss_v[0]));

  quick_spi_hard_ctrl #(.BYTES_ORDER(1), .BITS_ORDER(1), .CPOL(0), .CPHA(0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .start_transaction(start_v[1]),
    .slave(slave), .operation(operation), .outgoing_data(outgoing),
    .incoming_data(inc_v[1]), .end_of_transaction(eot_v[1]),
`ifdef QUICK_SPI_BUSY_EN
    .busy(busy_v[1]),
`endif
    .mosi(mosi_v[1]), .miso(miso), .sclk(sclk_v[1]), .ss_n(ss_v[1]));

  quick_spi_hard_ctrl #(.BYTES_ORDER(0), .BITS_ORDER(0), .CPOL(1), .CPHA(1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .start_transaction(start_v[2]),
    .slave(slave), .operation(operation), .outgoing_data(outgoing),
    .incoming_data(inc_v[2]), .end_of_transaction(eot_v[2]),
`ifdef QUICK_SPI_BUSY_EN
    .busy(busy_v[2]),
`endif
    .mosi(mosi_v[2]), .miso(miso), .sclk(sclk_v[2]), .ss_n(ss_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Runs one transaction on instance d starting at a negedge; returns at the negedge
  // where end_of_transaction is seen. seq[i] is the i-th mosi bit at the slave's
  // sample edge; miso presents rx_pat bit i before the (18+i)-th leading edge.
  task automatic txn(input int d, input logic cpol, input logic cpha,
                     input logic [1:0] exp_ss, input logic [7:0] rx_pat,
                     output logic [15:0] seq, output int nlow, output int neot,
                     output logic ss_ok, output logic first_lead_mosi);
    int caps;
    int leads;
    logic prev;
    logic is_lead;
    seq = '0; nlow = 0; neot = 0; ss_ok = 1'b1; caps = 0; leads = 0;
    first_lead_mosi = 1'b0;
    prev = cpol;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ss_v[d] != 2'b11) begin
        nlow++;
        if (ss_v[d] != exp_ss) ss_ok = 1'b0;
      end
      if (sclk_v[d] != prev) begin
        is_lead = (sclk_v[d] != cpol);
        if (is_lead && leads == 0) first_lead_mosi = mosi_v[d];
        if (is_lead != cpha) begin
          if (caps < 16) seq[caps] = mosi_v[d];
          caps++;
        end
        if (is_lead) leads++;
        prev = sclk_v[d];
      end
      if (eot_v[d]) begin
        neot = 1;
        break;
      end
      miso = (leads >= 18 && leads < 26) ? rx_pat[leads-18] : 1'b0;
      @(negedge clk);
    end
  endtask

  logic [15:0] seq;
  int nlow, neot, n_e, lowc0, lowc1, hic, tg;
  logic ss_ok, flm, prev_s;

  initial begin
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_ss_n", 32'(ss_v[d]), 32'h3);
      check("reset_mosi", 32'(mosi_v[d]), 32'h0);
      check("reset_eot", 32'(eot_v[d]), 32'h0);
      check("reset_incoming", 32'(inc_v[d]), 32'h0);
    end
    check("reset_sclk_cpol0", 32'(sclk_v[0]), 32'h0);
    check("reset_sclk_cpol1", 32'(sclk_v[2]), 32'h1);
    reset = 1'b0;
    @(negedge clk);

    // LE/LSB write of 0xCC82: bits 0,1,0,0,0,0,0,1, 0,0,1,1,0,0,1,1 -> seq 0xCC82.
    outgoing = 16'hCC82; slave = 2'd1; operation = 1'b0;
    txn(0, 1'b0, 1'b0, 2'b01, 8'h00, seq, nlow, neot, ss_ok, flm);
    check("le_write_mosi", 32'(seq), 32'h0000CC82);
    check("le_write_ss_n", 32'(ss_ok), 32'h1);
    check("le_write_len", 32'(nlow), 32'd38);
    check("le_write_eot", 32'(neot), 32'h1);
    @(negedge clk);
    check("le_write_single_pulse", 32'(eot_v[0]), 32'h0);

    // BE/MSB: bits 1,1,0,0,1,1,0,0, 1,0,0,0,0,0,1,0 -> seq 0x4133.
    @(negedge clk);
    txn(1, 1'b0, 1'b0, 2'b01, 8'h00, seq, nlow, neot, ss_ok, flm);
    check("be_write_mosi", 32'(seq), 32'h00004133);
    check("be_write_eot", 32'(neot), 32'h1);

    // Slave index out of range: no select, still completes.
    @(negedge clk);
    slave = 2'd2;
    txn(0, 1'b0, 1'b0, 2'b01, 8'h00, seq, nlow, neot, ss_ok, flm);
    check("bad_slave_no_select", 32'(nlow), 32'd0);
    check("bad_slave_eot", 32'(neot), 32'h1);

    // LE/LSB read; miso 1,0,1,0,1,0,0,1 -> 0x95.
    @(negedge clk);
    slave = 2'd0; operation = 1'b1; outgoing = 16'h1234;
    txn(0, 1'b0, 1'b0, 2'b10, 8'h95, seq, nlow, neot, ss_ok, flm);
    check("read_incoming", 32'(inc_v[0]), 32'h95);
    check("read_len", 32'(nlow), 32'd52);
    check("read_ss_n", 32'(ss_ok), 32'h1);
    check("read_eot", 32'(neot), 32'h1);

    @(negedge clk);
    operation = 1'b0;
    txn(0, 1'b0, 1'b0, 2'b10, 8'h00, seq, nlow, neot, ss_ok, flm);
    check("write_keeps_incoming", 32'(inc_v[0]), 32'h95);

    // Back-to-back: start held, operation flipped at each end pulse.
    @(negedge clk);
    operation = 1'b0; miso = 1'b1; start_v[0] = 1'b1;
    n_e = 0; lowc0 = 0; lowc1 = 0; hic = 0;
    for (int c = 0; c < 300 && n_e < 2; c++) begin
      @(negedge clk);
      if (eot_v[0]) begin
        n_e++;
        operation = ~operation;
        if (n_e == 2) start_v[0] = 1'b0;
      end
      if (ss_v[0] != 2'b11) begin
        if (n_e == 0) lowc0++; else lowc1++;
      end else if (n_e == 1 && lowc1 == 0) begin
        hic++;
      end
    end
    check("b2b_two_pulses", 32'(n_e), 32'd2);
    check("b2b_write_len", 32'(lowc0), 32'd38);
    check("b2b_read_len", 32'(lowc1), 32'd52);
    check("b2b_gap", 32'(hic), 32'd2);
    check("b2b_incoming", 32'(inc_v[0]), 32'hFF);
    miso = 1'b0;

    // Abort: enable drops after 10 toggles.
    @(negedge clk);
    operation = 1'b0; slave = 2'd1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    prev_s = 1'b0; tg = 0;
    for (int c = 0; c < 100 && tg < 10; c++) begin
      @(negedge clk);
      if (sclk_v[0] != prev_s) begin
        tg++;
        prev_s = sclk_v[0];
      end
    end
    check("abort_reach", 32'(tg), 32'd10);
    enable = 1'b0;
    @(negedge clk);
    check("abort_ss_n", 32'(ss_v[0]), 32'h3);
    check("abort_sclk", 32'(sclk_v[0]), 32'h0);
    n_e = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (eot_v[0]) n_e++;
    end
    check("abort_no_eot", 32'(n_e), 32'd0);
    check("abort_incoming", 32'(inc_v[0]), 32'hFF);
    enable = 1'b1;
    @(negedge clk);
    outgoing = 16'hCC82;
    txn(0, 1'b0, 1'b0, 2'b01, 8'h00, seq, nlow, neot, ss_ok, flm);
    check("after_abort_write", 32'(seq), 32'h0000CC82);

    // CPOL=1, CPHA=1 write of 0x0001, first bit driven on first falling edge.
    @(negedge clk);
    outgoing = 16'h0001; slave = 2'd1; operation = 1'b0;
    txn(2, 1'b1, 1'b1, 2'b01, 8'h00, seq, nlow, neot, ss_ok, flm);
    check("cpha1_first_bit", 32'(flm), 32'h1);
    check("cpha1_mosi", 32'(seq), 32'h00000001);
    check("cpha1_len", 32'(nlow), 32'd38);
    @(negedge clk);
    check("cpha1_sclk_idle", 32'(sclk_v[2]), 32'h1);

    // Reset in the middle of a read.
    operation = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("midread_active", 32'(ss_v[0]), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_ss_n", 32'(ss_v[0]), 32'h3);
    check("midreset_sclk", 32'(sclk_v[0]), 32'h0);
    check("midreset_mosi", 32'(mosi_v[0]), 32'h0);
    check("midreset_incoming", 32'(inc_v[0]), 32'h0);
    check("midreset_eot", 32'(eot_v[0]), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 32'(ss_v[0]), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
